// File: rtl/my_nios2_system_cpu_oci_dct_packer_if.sv
// Handshake bundle for the OCI DCT packer.
//   sym_valid/sym_data/sym_ready       : trace symbol stream into the packer
//   frame_valid/frame_data/frame_count : packed frame stream out of the packer
//   frame_ready                        : downstream acceptance of a frame
// slave modport = packer side, master modport = feeder/consumer side.
interface my_nios2_system_cpu_oci_dct_packer_if #(
   parameter int unsigned SYM_W = 2,
   parameter int unsigned SYMS  = 15,
   parameter int unsigned CNT_W = 4
);
   logic                    sym_valid;
   logic [SYM_W-1:0]        sym_data;
   logic                    sym_ready;
   logic                    frame_valid;
   logic [SYM_W*SYMS-1:0]   frame_data;
   logic [CNT_W-1:0]        frame_count;
   logic                    frame_ready;

   modport slave (
      input  sym_valid,
      input  sym_data,
      output sym_ready,
      output frame_valid,
      output frame_data,
      output frame_count,
      input  frame_ready
   );

   modport master (
      output sym_valid,
      output sym_data,
      input  sym_ready,
      input  frame_valid,
      input  frame_data,
      input  frame_count,
      output frame_ready
   );
endinterface

// File: rtl/my_nios2_system_cpu_oci_dct_packer.sv
// OCI DCT packer: collects 2-bit trace symbols into a 30-bit capture buffer,
// presents full or flushed frames over valid/ready, and raises the
// end-of-test markers consumed by the trace monitor.
//   clk            : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   bus (slave)    : symbol input stream and frame output stream
//   flush_req      : close the current partial frame
//   stop_req       : end-of-test request
//   dct_buffer     : live capture buffer
//   dct_count      : live fill count
//   test_ending    : one-cycle end-of-test pulse
//   test_has_ended : sticky end-of-test flag
module my_nios2_system_cpu_oci_dct_packer #(
   parameter int unsigned SYM_W = 2,
   parameter int unsigned SYMS  = 15,
   parameter int unsigned CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   my_nios2_system_cpu_oci_dct_packer_if.slave bus,
   input  logic                  flush_req,
   input  logic                  stop_req,
   output logic [SYM_W*SYMS-1:0] dct_buffer,
   output logic [CNT_W-1:0]      dct_count,
   output logic                  test_ending,
   output logic                  test_has_ended
);

   typedef enum logic [1:0] {ACCUM, PEND, ENDING, ENDED} state_t;

   state_t                state;
   logic [SYM_W*SYMS-1:0] buffer;
   logic [CNT_W-1:0]      count;
   logic                  stop_pending;
   logic                  sym_ready_q;
   logic                  frame_valid_q;
   logic                  test_ending_q;
   logic                  test_has_ended_q;

   logic                  accept;
   logic [CNT_W-1:0]      cnt_post;
   logic [SYM_W*SYMS-1:0] buf_post;
   logic                  close;

   // Post-accept view of the buffer; closing decisions use these values so a
   // symbol arriving with flush/stop lands in the frame it closes.
   always_comb begin
      accept   = bus.sym_valid && sym_ready_q;
      cnt_post = count + CNT_W'(accept);
      buf_post = buffer;
      if (accept) begin
         for (int unsigned k = 0; k < SYMS; k++) begin
            if (CNT_W'(k) == count) buf_post[k*SYM_W +: SYM_W] = bus.sym_data;
         end
      end
      close = (cnt_post == CNT_W'(SYMS)) ||
              ((flush_req || stop_req) && (cnt_post != '0));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ACCUM;
         buffer           <= '0;
         count            <= '0;
         stop_pending     <= 1'b0;
         sym_ready_q      <= 1'b0;
         frame_valid_q    <= 1'b0;
         test_ending_q    <= 1'b0;
         test_has_ended_q <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               buffer <= buf_post;
               count  <= cnt_post;
               if (close) begin
                  state         <= PEND;
                  frame_valid_q <= 1'b1;
                  sym_ready_q   <= 1'b0;
                  stop_pending  <= stop_req;
               end else if (stop_req) begin
                  // Only reachable with an empty buffer and no accept.
                  state         <= ENDING;
                  test_ending_q <= 1'b1;
                  sym_ready_q   <= 1'b0;
               end else begin
                  sym_ready_q <= 1'b1;
               end
            end
            PEND: begin
               if (bus.frame_ready) begin
                  buffer        <= '0;
                  count         <= '0;
                  frame_valid_q <= 1'b0;
                  stop_pending  <= 1'b0;
                  // A stop coinciding with the frame handshake is not lost.
                  if (stop_pending || stop_req) begin
                     state         <= ENDING;
                     test_ending_q <= 1'b1;
                  end else begin
                     state       <= ACCUM;
                     sym_ready_q <= 1'b1;
                  end
               end else if (stop_req) begin
                  stop_pending <= 1'b1;
               end
            end
            ENDING: begin
               test_ending_q    <= 1'b0;
               test_has_ended_q <= 1'b1;
               state            <= ENDED;
            end
            ENDED: begin
               state <= ENDED;
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

   assign bus.sym_ready   = sym_ready_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_data  = buffer;
   assign bus.frame_count = count;
   assign dct_buffer      = buffer;
   assign dct_count       = count;
   assign test_ending     = test_ending_q;
   assign test_has_ended  = test_has_ended_q;

endmodule

// File: tb/tb_my_nios2_system_cpu_oci_dct_packer.sv
// Scoreboard bench for the OCI DCT packer: directed stimulus pushes expected
// frames into a queue; a monitor pops and compares on every frame handshake.
module tb_my_nios2_system_cpu_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush_req;
   logic        stop_req;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [29:0] d;
      logic [3:0]  c;
   } frm_t;
   frm_t exp_q[$];

   my_nios2_system_cpu_oci_dct_packer_if #(.SYM_W(2), .SYMS(15), .CNT_W(4)) bus_if ();

   my_nios2_system_cpu_oci_dct_packer #(.SYM_W(2), .SYMS(15), .CNT_W(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus_if),
      .flush_req      (flush_req),
      .stop_req       (stop_req),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [1:0] d);
      int n;
      n = 0;
      bus_if.sym_valid = 1'b1;
      bus_if.sym_data  = d;
      while (!bus_if.sym_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("sym_ready_timeout", 32'd0, 32'd1);
      step();
      bus_if.sym_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   // Monitor: inputs are stable at the falling edge, so a handshake seen here
   // is the one the next rising edge takes.
   always @(negedge clk) begin
      if (reset_n && bus_if.frame_valid && bus_if.frame_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", {2'b0, bus_if.frame_data}, 32'd0);
         end else begin
            frm_t e;
            e = exp_q.pop_front();
            chk("frame_data", {2'b0, bus_if.frame_data}, {2'b0, e.d});
            chk("frame_count", {28'b0, bus_if.frame_count}, {28'b0, e.c});
         end
      end
   end

   initial begin
      reset_n            = 1'b0;
      flush_req          = 1'b0;
      stop_req           = 1'b0;
      bus_if.sym_valid   = 1'b0;
      bus_if.sym_data    = '0;
      bus_if.frame_ready = 1'b1;
      #1;
      chk("rst_count", {28'b0, dct_count}, 32'd0);
      chk("rst_buffer", {2'b0, dct_buffer}, 32'd0);
      chk("rst_sym_ready", {31'b0, bus_if.sym_ready}, 32'd0);
      chk("rst_frame_valid", {31'b0, bus_if.frame_valid}, 32'd0);
      chk("rst_ending", {30'b0, test_ending, test_has_ended}, 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // Full frame, symbols k%4: bytes 0xE4, top symbols 0,1,2 -> 0x24E4E4E4.
      exp_q.push_back('{d: 30'h24E4E4E4, c: 4'd15});
      for (int i = 0; i < 15; i++) send_sym(2'(i % 4));
      chk("full_frame_valid", {31'b0, bus_if.frame_valid}, 32'd1);
      chk("full_count", {28'b0, dct_count}, 32'd15);
      chk("full_sym_ready", {31'b0, bus_if.sym_ready}, 32'd0);
      step();
      chk("after_full_count", {28'b0, dct_count}, 32'd0);
      chk("after_full_ready", {31'b0, bus_if.sym_ready}, 32'd1);
      chk("after_full_valid", {31'b0, bus_if.frame_valid}, 32'd0);

      // Flushed partial frame 3,2,1 held under back-pressure.
      bus_if.frame_ready = 1'b0;
      exp_q.push_back('{d: 30'h1B, c: 4'd3});
      send_sym(2'd3);
      send_sym(2'd2);
      send_sym(2'd1);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      bus_if.sym_valid = 1'b1;
      bus_if.sym_data  = 2'd0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'b0, bus_if.frame_valid}, 32'd1);
         chk("stall_data", {2'b0, bus_if.frame_data}, 32'h1B);
         chk("stall_count", {28'b0, bus_if.frame_count}, 32'd3);
         chk("stall_sym_ready", {31'b0, bus_if.sym_ready}, 32'd0);
         step();
      end
      bus_if.sym_valid   = 1'b0;
      bus_if.frame_ready = 1'b1;
      step();
      chk("flush_done_valid", {31'b0, bus_if.frame_valid}, 32'd0);
      chk("flush_done_ready", {31'b0, bus_if.sym_ready}, 32'd1);

      // Flush on empty buffer is ignored.
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("empty_flush_valid", {31'b0, bus_if.frame_valid}, 32'd0);
      chk("empty_flush_ready", {31'b0, bus_if.sym_ready}, 32'd1);
      chk("empty_flush_count", {28'b0, dct_count}, 32'd0);

      // Accept + flush with count 4: 1,1,1,1,2 -> 0x255, five symbols.
      exp_q.push_back('{d: 30'h255, c: 4'd5});
      for (int i = 0; i < 4; i++) send_sym(2'd1);
      bus_if.sym_valid = 1'b1;
      bus_if.sym_data  = 2'd2;
      flush_req        = 1'b1;
      step();
      bus_if.sym_valid = 1'b0;
      flush_req        = 1'b0;
      chk("acc_flush_valid", {31'b0, bus_if.frame_valid}, 32'd1);
      chk("acc_flush_count", {28'b0, bus_if.frame_count}, 32'd5);
      step();

      // stop_req while PEND under back-pressure: ENDING right after handshake.
      bus_if.frame_ready = 1'b0;
      exp_q.push_back('{d: 30'h2A, c: 4'd3});
      for (int i = 0; i < 3; i++) send_sym(2'd2);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      stop_req  = 1'b1;
      step();
      stop_req  = 1'b0;
      chk("pend_stop_valid", {31'b0, bus_if.frame_valid}, 32'd1);
      chk("pend_stop_noend", {31'b0, test_ending}, 32'd0);
      bus_if.frame_ready = 1'b1;
      step();
      chk("pend_stop_ending", {31'b0, test_ending}, 32'd1);
      step();
      chk("pend_stop_ended", {30'b0, test_ending, test_has_ended}, 32'd1);
      do_reset();

      // stop_req with two symbols buffered: 3,1 -> 0x7.
      exp_q.push_back('{d: 30'h7, c: 4'd2});
      send_sym(2'd3);
      send_sym(2'd1);
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      chk("stop2_valid", {31'b0, bus_if.frame_valid}, 32'd1);
      chk("stop2_count", {28'b0, bus_if.frame_count}, 32'd2);
      step();
      chk("stop2_ending", {31'b0, test_ending}, 32'd1);
      chk("stop2_not_ended", {31'b0, test_has_ended}, 32'd0);
      step();
      chk("stop2_pulse_done", {31'b0, test_ending}, 32'd0);
      bus_if.sym_valid = 1'b1;
      bus_if.sym_data  = 2'd3;
      flush_req        = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ended_flag", {31'b0, test_has_ended}, 32'd1);
         chk("ended_sym_ready", {31'b0, bus_if.sym_ready}, 32'd0);
         chk("ended_count", {28'b0, dct_count}, 32'd0);
         chk("ended_frame_valid", {31'b0, bus_if.frame_valid}, 32'd0);
         step();
      end
      bus_if.sym_valid = 1'b0;
      flush_req        = 1'b0;
      do_reset();

      // stop_req on an empty buffer: ENDING on the next edge.
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      chk("stop0_ending", {31'b0, test_ending}, 32'd1);
      chk("stop0_valid", {31'b0, bus_if.frame_valid}, 32'd0);
      step();
      chk("stop0_ended", {30'b0, test_ending, test_has_ended}, 32'd1);
      do_reset();

      // Asynchronous reset mid-cycle with seven symbols buffered.
      for (int i = 0; i < 7; i++) send_sym(2'd3);
      chk("pre_reset_count", {28'b0, dct_count}, 32'd7);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_count", {28'b0, dct_count}, 32'd0);
      chk("async_rst_buffer", {2'b0, dct_buffer}, 32'd0);
      chk("async_rst_ready", {31'b0, bus_if.sym_ready}, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      exp_q.push_back('{d: 30'h24E4E4E4, c: 4'd15});
      for (int i = 0; i < 15; i++) send_sym(2'(i % 4));
      chk("resume_valid", {31'b0, bus_if.frame_valid}, 32'd1);
      step();
      step();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
